// File: rtl/frac_clk_pkg.sv
// -----------------------------------------------------------------------------
// frac_clk_pkg
//   Shared types and helpers for the fractional clock-enable generator.
//   - state_t     : configuration FSM states (IDLE, APPLY)
//   - ch_w()      : width of the channel-select field, never below 1 bit
//   - incr_legal(): an increment is legal when it does not exceed half of the
//                   accumulator range, i.e. f_out <= f_clk/2
//   Supports ACC_W from 2 to 64.
// -----------------------------------------------------------------------------
package frac_clk_pkg;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    APPLY = 1'b1
  } state_t;

  function automatic int ch_w(input int n_ch);
    return (n_ch <= 2) ? 1 : $clog2(n_ch);
  endfunction

  function automatic logic incr_legal(input logic [63:0] incr, input int acc_w);
    return incr <= (64'd1 << (acc_w - 1));
  endfunction

endpackage

// File: rtl/frac_clk_chan.sv
// -----------------------------------------------------------------------------
// frac_clk_chan
//   One NCO channel: an ACC_W-bit phase accumulator that adds its increment
//   every cycle. The carry out of the add becomes a one-cycle clock enable and
//   the accumulator MSB becomes a roughly square divided clock. Both outputs
//   are registered and update on the same edge as the accumulator.
//
// Ports
//   clk         in   system clock
//   nrst        in   async active-low reset
//   load        in   load increment and accumulator preload this cycle
//   load_incr   in   increment to load
//   load_phase  in   accumulator preload value
//   clr         in   phase-align: zero the accumulator and outputs
//   ce          out  one-cycle pulse on accumulator wrap
//   clk_div     out  accumulator MSB
//
// Priority: load > clr > normal accumulate.
// -----------------------------------------------------------------------------
module frac_clk_chan #(
  parameter int               ACC_W    = 32,
  parameter logic [ACC_W-1:0] RST_INCR = '0
) (
  input  logic             clk,
  input  logic             nrst,
  input  logic             load,
  input  logic [ACC_W-1:0] load_incr,
  input  logic [ACC_W-1:0] load_phase,
  input  logic             clr,
  output logic             ce,
  output logic             clk_div
);

  logic [ACC_W-1:0] acc;
  logic [ACC_W-1:0] incr;
  logic [ACC_W:0]   sum;

  // One extra bit keeps the wrap carry; with incr == 0 the sum equals acc,
  // so the accumulator freezes, ce stays low and clk_div holds.
  assign sum = {1'b0, acc} + {1'b0, incr};

  // NOTE: state registers use non-blocking (<=) so every flop samples the
  // pre-edge values; blocking here would create order-dependent simulation.
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      acc     <= '0;
      incr    <= RST_INCR;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else if (load) begin
      incr    <= load_incr;
      acc     <= load_phase;
      ce      <= 1'b0;
      clk_div <= load_phase[ACC_W-1];
    end else if (clr) begin
      acc     <= '0;
      ce      <= 1'b0;
      clk_div <= 1'b0;
    end else begin
      acc     <= sum[ACC_W-1:0];
      ce      <= sum[ACC_W];
      clk_div <= sum[ACC_W-1];
    end
  end

endmodule

// File: rtl/frac_clk_gen.sv
// -----------------------------------------------------------------------------
// frac_clk_gen
//   Multi-channel fractional clock-enable generator. N_CH independent NCO
//   channels derive programmable-rate enables (ce_o) and divided clocks
//   (clk_o) from clk: f_out = incr * f_clk / 2^ACC_W. Rates and phases are
//   rewritten at run time through a valid/ready port; locked reports that the
//   configuration has been quiet for LOCK_CYCLES cycles.
//
// Parameters
//   N_CH          number of channels (1..16)
//   ACC_W         accumulator width (2..64)
//   DEFAULT_INCR  reset increment of every channel (0 = stopped)
//   LOCK_CYCLES   quiet cycles before locked rises (>= 1)
//
// Ports
//   clk        in   system clock
//   nrst       in   async active-low reset
//   cfg_valid  in   config write request
//   cfg_ready  out  write accepted when cfg_valid & cfg_ready
//   cfg_chan   in   target channel
//   cfg_incr   in   new increment (legal when <= 2^(ACC_W-1))
//   cfg_phase  in   accumulator preload
//   cfg_err    out  one-cycle pulse: write rejected, nothing changed
//   sync       in   phase-align strobe (only with FRAC_CLK_SYNC_EN)
//   ce_o       out  one-cycle enable per accumulator wrap, per channel
//   clk_o      out  registered accumulator MSB, per channel
//   locked     out  configuration settled
//
// Build option
//   FRAC_CLK_SYNC_EN  adds the sync port; a sync cycle zeroes every
//                     accumulator except the one being written that cycle.
//
// A write takes two cycles: the accept edge captures the inputs (the caller
// may change them afterwards), the APPLY edge checks and loads them. cfg_ready
// is low during APPLY, so at most one write lands every two cycles.
// -----------------------------------------------------------------------------
module frac_clk_gen
  import frac_clk_pkg::*;
#(
  parameter int               N_CH         = 4,
  parameter int               ACC_W        = 32,
  parameter logic [ACC_W-1:0] DEFAULT_INCR = '0,
  parameter int               LOCK_CYCLES  = 1024
) (
  input  logic                  clk,
  input  logic                  nrst,
  input  logic                  cfg_valid,
  output logic                  cfg_ready,
  input  logic [ch_w(N_CH)-1:0] cfg_chan,
  input  logic [ACC_W-1:0]      cfg_incr,
  input  logic [ACC_W-1:0]      cfg_phase,
  output logic                  cfg_err,
`ifdef FRAC_CLK_SYNC_EN
  input  logic                  sync,
`endif
  output logic [N_CH-1:0]       ce_o,
  output logic [N_CH-1:0]       clk_o,
  output logic                  locked
);

  localparam int CH_W   = ch_w(N_CH);
  localparam int LOCK_W = $clog2(LOCK_CYCLES + 1);
  localparam logic [LOCK_W-1:0] LOCK_MAX  = LOCK_W'(LOCK_CYCLES);
  localparam logic [LOCK_W-1:0] LOCK_LAST = LOCK_W'(LOCK_CYCLES - 1);

  state_t            state;
  logic              running;   // set from the first edge after reset
  logic [CH_W-1:0]   chan_q;
  logic [ACC_W-1:0]  incr_q;
  logic [ACC_W-1:0]  phase_q;
  logic [31:0]       chan_ext;
  logic              chan_ok;
  logic              incr_ok;
  logic              apply_ok;
  logic [N_CH-1:0]   load_vec;
  logic              sync_clr;
  logic [LOCK_W-1:0] lock_cnt;

`ifdef FRAC_CLK_SYNC_EN
  assign sync_clr = sync;
`else
  assign sync_clr = 1'b0;
`endif

  // ---------------------------------------------------------------------------
  // Legality of the captured write and per-channel load strobes
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default before any conditional
  // assignment, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    chan_ext             = '0;
    chan_ext[CH_W-1:0]   = chan_q;
    chan_ok              = chan_ext < 32'(N_CH);
    incr_ok              = incr_legal(64'(incr_q), ACC_W);
    apply_ok             = (state == APPLY) && chan_ok && incr_ok;
    load_vec             = '0;
    for (int i = 0; i < N_CH; i++) begin
      load_vec[i] = apply_ok && (chan_q == CH_W'(i));
    end
  end

  // ---------------------------------------------------------------------------
  // Configuration FSM: capture on accept, check and load on APPLY
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      state     <= IDLE;
      cfg_ready <= 1'b0;
      cfg_err   <= 1'b0;
      running   <= 1'b0;
      chan_q    <= '0;
      incr_q    <= '0;
      phase_q   <= '0;
    end else begin
      running <= 1'b1;
      cfg_err <= 1'b0;
      case (state)
        IDLE: begin
          cfg_ready <= 1'b1;
          if (cfg_valid && cfg_ready) begin
            state     <= APPLY;
            cfg_ready <= 1'b0;
            chan_q    <= cfg_chan;
            incr_q    <= cfg_incr;
            phase_q   <= cfg_phase;
          end
        end
        APPLY: begin
          state     <= IDLE;
          cfg_ready <= 1'b1;
          cfg_err   <= !(chan_ok && incr_ok);
        end
        default: begin
          state     <= IDLE;
          cfg_ready <= 1'b0;
        end
      endcase
    end
  end

  // ---------------------------------------------------------------------------
  // Lock tracking. Counting starts one edge after reset so that the first
  // locked rise lands exactly LOCK_CYCLES cycles after cfg_ready first rises.
  // Rejected writes and sync pulses leave the lock untouched.
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge nrst) begin
    if (!nrst) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (apply_ok) begin
      lock_cnt <= '0;
      locked   <= 1'b0;
    end else if (running) begin
      if (lock_cnt != LOCK_MAX) begin
        lock_cnt <= lock_cnt + 1'b1;
      end
      locked <= locked | (lock_cnt == LOCK_LAST);
    end
  end

  // ---------------------------------------------------------------------------
  // NCO channels; a write only touches the addressed channel
  // ---------------------------------------------------------------------------
  for (genvar i = 0; i < N_CH; i++) begin : g_chan
    frac_clk_chan #(
      .ACC_W    (ACC_W),
      .RST_INCR (DEFAULT_INCR)
    ) u_chan (
      .clk        (clk),
      .nrst       (nrst),
      .load       (load_vec[i]),
      .load_incr  (incr_q),
      .load_phase (phase_q),
      .clr        (sync_clr),
      .ce         (ce_o[i]),
      .clk_div    (clk_o[i])
    );
  end

endmodule

// File: tb/tb_frac_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_frac_clk_gen
//   Self-checking bench for frac_clk_gen (N_CH=2, ACC_W=8, LOCK_CYCLES=8).
//   A cycle-level reference model predicts every output before each clock
//   edge; the prediction goes into a scoreboard queue and is popped and
//   compared 1 time unit after the edge. Targeted measurements (lock timing,
//   pulse spacing, ready pattern, sync alignment) are checked on top, and a
//   second N_CH=3 instance covers the out-of-range channel rejection.
//   Define FRAC_CLK_SYNC_EN to build and exercise the sync port.
// -----------------------------------------------------------------------------
module tb_frac_clk_gen;

  localparam int N_CH        = 2;
  localparam int ACC_W       = 8;
  localparam int LOCK_CYCLES = 8;
  localparam int CH_W        = 1;

  logic              clk       = 1'b0;
  logic              nrst      = 1'b0;
  logic              cfg_valid = 1'b0;
  logic [CH_W-1:0]   cfg_chan  = '0;
  logic [ACC_W-1:0]  cfg_incr  = '0;
  logic [ACC_W-1:0]  cfg_phase = '0;
  logic              cfg_ready;
  logic              cfg_err;
  logic [N_CH-1:0]   ce_o;
  logic [N_CH-1:0]   clk_o;
  logic              locked;
`ifdef FRAC_CLK_SYNC_EN
  logic              sync      = 1'b0;
  logic              sync3     = 1'b0;
`endif

  // Second instance with three channels
  logic              v3     = 1'b0;
  logic [1:0]        chan3  = '0;
  logic [ACC_W-1:0]  incr3  = '0;
  logic [ACC_W-1:0]  phase3 = '0;
  logic              ready3;
  logic              err3;
  logic [2:0]        ce3;
  logic [2:0]        clko3;
  logic              locked3;

  always #5 clk = ~clk;

  frac_clk_gen #(
    .N_CH         (N_CH),
    .ACC_W        (ACC_W),
    .DEFAULT_INCR (8'd0),
    .LOCK_CYCLES  (LOCK_CYCLES)
  ) dut (
    .clk       (clk),
    .nrst      (nrst),
    .cfg_valid (cfg_valid),
    .cfg_ready (cfg_ready),
    .cfg_chan  (cfg_chan),
    .cfg_incr  (cfg_incr),
    .cfg_phase (cfg_phase),
    .cfg_err   (cfg_err),
`ifdef FRAC_CLK_SYNC_EN
    .sync      (sync),
`endif
    .ce_o      (ce_o),
    .clk_o     (clk_o),
    .locked    (locked)
  );

  frac_clk_gen #(
    .N_CH         (3),
    .ACC_W        (ACC_W),
    .DEFAULT_INCR (8'd0),
    .LOCK_CYCLES  (LOCK_CYCLES)
  ) dut3 (
    .clk       (clk),
    .nrst      (nrst),
    .cfg_valid (v3),
    .cfg_ready (ready3),
    .cfg_chan  (chan3),
    .cfg_incr  (incr3),
    .cfg_phase (phase3),
    .cfg_err   (err3),
`ifdef FRAC_CLK_SYNC_EN
    .sync      (sync3),
`endif
    .ce_o      (ce3),
    .clk_o     (clko3),
    .locked    (locked3)
  );

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int n_vec = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", tag, got, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------------------
  // Reference model and scoreboard
  // ---------------------------------------------------------------------------
  typedef struct packed {
    logic [N_CH-1:0] ce;
    logic [N_CH-1:0] clk;
    logic            ready;
    logic            err;
    logic            locked;
  } exp_t;

  exp_t sb_q[$];

  int              m_acc[N_CH];
  int              m_inc[N_CH];
  logic [N_CH-1:0] m_ce;
  logic [N_CH-1:0] m_clk;
  bit              m_ready, m_err, m_locked, m_pend, m_started;
  int              m_cnt, m_chan, m_cinc, m_cph;

  task automatic model_reset();
    for (int i = 0; i < N_CH; i++) begin
      m_acc[i] = 0;
      m_inc[i] = 0;
    end
    m_ce = '0; m_clk = '0;
    m_ready = 0; m_err = 0; m_locked = 0; m_pend = 0; m_started = 0;
    m_cnt = 0; m_chan = 0; m_cinc = 0; m_cph = 0;
  endtask

  // Advance the model by one clock edge using the inputs currently driven.
  task automatic model_step();
    bit legal;
    bit sy;
    int s;
`ifdef FRAC_CLK_SYNC_EN
    sy = sync;
`else
    sy = 1'b0;
`endif
    legal = m_pend && (m_chan < N_CH) && (m_cinc <= 128);
    for (int i = 0; i < N_CH; i++) begin
      if (legal && m_chan == i) begin
        m_inc[i] = m_cinc;
        m_acc[i] = m_cph;
        m_ce[i]  = 1'b0;
        m_clk[i] = (m_cph >= 128);
      end else if (sy) begin
        m_acc[i] = 0;
        m_ce[i]  = 1'b0;
        m_clk[i] = 1'b0;
      end else begin
        s        = m_acc[i] + m_inc[i];
        m_ce[i]  = (s >= 256);
        m_acc[i] = s % 256;
        m_clk[i] = (m_acc[i] >= 128);
      end
    end
    m_err = m_pend && !legal;
    if (legal) begin
      m_cnt    = 0;
      m_locked = 0;
    end else if (m_started) begin
      m_locked = m_locked || (m_cnt == LOCK_CYCLES - 1);
      if (m_cnt < LOCK_CYCLES) m_cnt++;
    end
    if (m_pend) begin
      m_pend  = 0;
      m_ready = 1;
    end else if (m_ready && cfg_valid) begin
      m_pend  = 1;
      m_ready = 0;
      m_chan  = int'(cfg_chan);
      m_cinc  = int'(cfg_incr);
      m_cph   = int'(cfg_phase);
    end else begin
      m_ready = 1;
    end
    m_started = 1;
  endtask

  // One clock cycle: predict, wait for the edge, compare away from it.
  task automatic tick();
    exp_t e;
    model_step();
    e.ce = m_ce; e.clk = m_clk; e.ready = m_ready; e.err = m_err; e.locked = m_locked;
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    e = sb_q.pop_front();
    check("ce_o",      32'(ce_o),      32'(e.ce));
    check("clk_o",     32'(clk_o),     32'(e.clk));
    check("cfg_ready", 32'(cfg_ready), 32'(e.ready));
    check("cfg_err",   32'(cfg_err),   32'(e.err));
    check("locked",    32'(locked),    32'(e.locked));
  endtask

  task automatic run(input int n);
    repeat (n) tick();
  endtask

  task automatic wait_ready();
    for (int i = 0; i < 10 && !cfg_ready; i++) tick();
    if (!cfg_ready) check("ready_timeout", 32'(cfg_ready), 32'd1);
  endtask

  // Single write; inputs are scrambled after the accept edge.
  task automatic cfg_write(input int chan, input int incr, input int phase);
    wait_ready();
    cfg_valid = 1'b1;
    cfg_chan  = 1'(chan);
    cfg_incr  = 8'(incr);
    cfg_phase = 8'(phase);
    tick();
    cfg_valid = 1'b0;
    cfg_chan  = ~cfg_chan;
    cfg_incr  = 8'hA5;
    cfg_phase = 8'h5A;
    tick();
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus
  // ---------------------------------------------------------------------------
  initial begin
    int t_ready, t_lock, first, second, n_hi, prev0, bad0, n_first;
    int t1[$];
    int f0, f1;
    logic [3:0] rdy_seq;
    int b2b_incr[4];
    b2b_incr = '{16, 32, 8, 100};

    // --- reset state -------------------------------------------------------
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check("rst_ce_o",   32'(ce_o),      32'd0);
    check("rst_clk_o",  32'(clk_o),     32'd0);
    check("rst_ready",  32'(cfg_ready), 32'd0);
    check("rst_err",    32'(cfg_err),   32'd0);
    check("rst_locked", 32'(locked),    32'd0);
    #2 nrst = 1'b1;

    // --- no writes: lock timing --------------------------------------------
    t_ready = -1; t_lock = -1;
    for (int i = 1; i <= 20; i++) begin
      tick();
      if (cfg_ready && t_ready < 0) t_ready = i;
      if (locked && t_lock < 0) t_lock = i;
    end
    check("first_ready", 32'(t_ready), 32'd1);
    check("lock_after_reset", 32'(t_lock - t_ready), 32'(LOCK_CYCLES));

    // --- ch0 incr=64 phase=0 ------------------------------------------------
    cfg_write(0, 64, 0);
    check("lock_drop_ch0", 32'(locked), 32'd0);
    first = -1; second = -1; n_hi = 0; t_lock = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ce_o[0]) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
      if (i <= 8 && clk_o[0]) n_hi++;
      if (locked && t_lock < 0) t_lock = i;
    end
    check("ch0_first_ce", 32'(first), 32'd4);
    check("ch0_ce_gap", 32'(second - first), 32'd4);
    check("ch0_clk_high", 32'(n_hi), 32'd4);
    check("lock_after_write", 32'(t_lock), 32'(LOCK_CYCLES));

    // --- ch1 incr=3: 85/85/86 spacing, ch0 undisturbed -----------------------
    cfg_write(1, 3, 0);
    prev0 = -1; bad0 = 0;
    for (int i = 1; i <= 350; i++) begin
      tick();
      if (ce_o[1]) t1.push_back(i);
      if (ce_o[0]) begin
        if (prev0 >= 0 && i - prev0 != 4) bad0++;
        prev0 = i;
      end
    end
    n_first = 0;
    foreach (t1[k]) if (t1[k] <= 256) n_first++;
    check("ch1_pulse_count", 32'(t1.size() >= 4), 32'd1);
    check("ch1_pulses_256", 32'(n_first), 32'd3);
    if (t1.size() >= 4) begin
      check("ch1_first", 32'(t1[0]), 32'd86);
      check("ch1_gap1", 32'(t1[1] - t1[0]), 32'd85);
      check("ch1_gap2", 32'(t1[2] - t1[1]), 32'd85);
      check("ch1_gap3", 32'(t1[3] - t1[2]), 32'd86);
    end
    check("ch0_gap_errors", 32'(bad0), 32'd0);

    // --- rejected writes and the legal boundary ------------------------------
    cfg_write(0, 200, 0);
    check("err_incr200", 32'(cfg_err), 32'd1);
    check("lock_kept_200", 32'(locked), 32'd1);
    tick();
    check("err_one_cycle", 32'(cfg_err), 32'd0);
    cfg_write(1, 129, 0);
    check("err_incr129", 32'(cfg_err), 32'd1);
    check("lock_kept_129", 32'(locked), 32'd1);
    run(8);
    cfg_write(1, 128, 0);
    check("ok_incr128", 32'(cfg_err), 32'd0);
    check("lock_drop_128", 32'(locked), 32'd0);
    run(4);

    // --- back-to-back valid held four cycles ---------------------------------
    wait_ready();
    rdy_seq = '0;
    for (int k = 0; k < 4; k++) begin
      cfg_valid = 1'b1;
      cfg_chan  = 1'b1;
      cfg_incr  = 8'(b2b_incr[k]);
      cfg_phase = 8'd0;
      rdy_seq[3-k] = cfg_ready;
      tick();
    end
    cfg_valid = 1'b0;
    check("b2b_ready_seq", 32'(rdy_seq), 32'b1010);
    first = -1; second = -1;
    for (int i = 1; i <= 80; i++) begin
      tick();
      if (ce_o[1]) begin
        if (first < 0) first = i;
        else if (second < 0) second = i;
      end
    end
    check("b2b_last_applied", 32'(second - first), 32'd32);

`ifdef FRAC_CLK_SYNC_EN
    // --- sync alignment --------------------------------------------------------
    cfg_write(0, 64, 0);
    cfg_write(1, 32, 77);
    run(3);
    sync = 1'b1;
    tick();
    sync = 1'b0;
    check("sync_clk_o", 32'(clk_o), 32'd0);
    f0 = -1; f1 = -1;
    for (int i = 1; i <= 12; i++) begin
      tick();
      if (ce_o[0] && f0 < 0) f0 = i;
      if (ce_o[1] && f1 < 0) f1 = i;
    end
    check("sync_ch0_ce", 32'(f0), 32'd4);
    check("sync_ch1_ce", 32'(f1), 32'd8);
`else
    f0 = 0; f1 = 0;
`endif

    // --- reset in the middle of a write ----------------------------------------
    wait_ready();
    cfg_valid = 1'b1;
    cfg_chan  = 1'b1;
    cfg_incr  = 8'd64;
    cfg_phase = 8'd0;
    tick();
    cfg_valid = 1'b0;
    nrst = 1'b0;
    #2;
    check("midrst_ce_o",   32'(ce_o),      32'd0);
    check("midrst_clk_o",  32'(clk_o),     32'd0);
    check("midrst_ready",  32'(cfg_ready), 32'd0);
    check("midrst_locked", 32'(locked),    32'd0);
    model_reset();
    sb_q.delete();
    nrst = 1'b1;
    n_hi = 0;
    for (int i = 1; i <= 20; i++) begin
      tick();
      n_hi += int'(ce_o[0]) + int'(ce_o[1]);
    end
    check("midrst_no_pulses", 32'(n_hi), 32'd0);

    // --- channel out of range (3-channel instance) ------------------------------
    check("dut3_locked_before", 32'(locked3), 32'd1);
    v3 = 1'b1; chan3 = 2'd3; incr3 = 8'd10;
    tick();
    v3 = 1'b0; chan3 = 2'd0;
    tick();
    check("dut3_err_chan", 32'(err3), 32'd1);
    check("dut3_lock_kept", 32'(locked3), 32'd1);
    v3 = 1'b1; chan3 = 2'd2; incr3 = 8'd64;
    tick();
    v3 = 1'b0;
    tick();
    check("dut3_ok_chan2", 32'(err3), 32'd0);
    check("dut3_lock_drop", 32'(locked3), 32'd0);
    run(2);
    check("dut3_clk2", 32'(clko3[2]), 32'd1);
    run(2);
    check("dut3_ce2", 32'(ce3[2]), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end

endmodule
